// File: rtl/hearts_manager.sv
`default_nettype none
// ============================================================================
// hearts_manager : player life count, post-hit invulnerability, sprite flicker
// Revision 1.0
// ============================================================================
module hearts_manager #(
    parameter int MAX_HEARTS   = 3,
    parameter int INV_FRAMES   = 120,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       hit,
    input  logic       heal,
    input  logic       restart,
    output logic [1:0] num_hearts,
    output logic       invincible,
    output logic       blink,
    output logic       damage_pulse,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam logic [1:0] c_max_hearts = 2'(MAX_HEARTS);
    localparam logic [7:0] c_inv_frames = 8'(INV_FRAMES);
    localparam logic [3:0] c_blink_last = 4'(BLINK_FRAMES - 1);

    state_t     r_state, w_state;
    logic [1:0] r_hearts, w_hearts;
    logic [7:0] r_timer, w_timer;
    logic [3:0] r_bcnt, w_bcnt;
    logic       r_blink, w_blink;
    logic       w_dmg;

    always_comb begin
        w_state  = r_state;
        w_hearts = r_hearts;
        w_timer  = r_timer;
        w_bcnt   = r_bcnt;
        w_blink  = r_blink;
        w_dmg    = 1'b0;
        if (restart) begin
            w_state  = ST_ALIVE;
            w_hearts = c_max_hearts;
            w_timer  = 8'd0;
            w_bcnt   = 4'd0;
            w_blink  = 1'b0;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (hit) begin
                        w_dmg    = 1'b1;
                        w_hearts = r_hearts - 2'd1;
                        if (r_hearts == 2'd1) begin
                            w_state = ST_DEAD;
                        end else begin
                            w_state = ST_INVULN;
                            w_timer = c_inv_frames;
                            w_bcnt  = 4'd0;
                            w_blink = 1'b1;
                        end
                    end else if (heal && (r_hearts < c_max_hearts)) begin
                        w_hearts = r_hearts + 2'd1;
                    end
                end
                ST_INVULN: begin
                    if (heal && (r_hearts < c_max_hearts)) begin
                        w_hearts = r_hearts + 2'd1;
                    end
                    if (frame_tick) begin
                        if (r_timer <= 8'd1) begin
                            // Window over: drop back to vulnerable, sprite visible
                            w_state = ST_ALIVE;
                            w_timer = 8'd0;
                            w_bcnt  = 4'd0;
                            w_blink = 1'b0;
                        end else begin
                            w_timer = r_timer - 8'd1;
                            if (r_bcnt == c_blink_last) begin
                                w_bcnt  = 4'd0;
                                w_blink = ~r_blink;
                            end else begin
                                w_bcnt = r_bcnt + 4'd1;
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    w_hearts = 2'd0;
                    w_timer  = 8'd0;
                    w_bcnt   = 4'd0;
                    w_blink  = 1'b0;
                end
                default: begin
                    w_state  = ST_ALIVE;
                    w_hearts = c_max_hearts;
                    w_timer  = 8'd0;
                    w_bcnt   = 4'd0;
                    w_blink  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_ALIVE;
            r_hearts     <= c_max_hearts;
            r_timer      <= 8'd0;
            r_bcnt       <= 4'd0;
            r_blink      <= 1'b0;
            damage_pulse <= 1'b0;
            invincible   <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_hearts     <= w_hearts;
            r_timer      <= w_timer;
            r_bcnt       <= w_bcnt;
            r_blink      <= w_blink;
            damage_pulse <= w_dmg;
            invincible   <= (w_state == ST_INVULN);
            game_over    <= (w_state == ST_DEAD);
        end
    end

    assign num_hearts = r_hearts;
    assign blink      = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_hearts_manager.sv
`default_nettype none
// ============================================================================
// tb_hearts_manager : vector table, hand sequences and random run vs model
// Revision 1.0
// ============================================================================
module tb_hearts_manager;

    localparam int MAX_HEARTS   = 3;
    localparam int INV_FRAMES   = 120;
    localparam int BLINK_FRAMES = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic       heal = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] num_hearts;
    logic       invincible;
    logic       blink;
    logic       damage_pulse;
    logic       game_over;

    int passed = 0;
    int total  = 0;

    hearts_manager #(
        .MAX_HEARTS  (MAX_HEARTS),
        .INV_FRAMES  (INV_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .hit         (hit),
        .heal        (heal),
        .restart     (restart),
        .num_hearts  (num_hearts),
        .invincible  (invincible),
        .blink       (blink),
        .damage_pulse(damage_pulse),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Reference model: hearts plus "frames elapsed since the hit"
    int m_hearts = MAX_HEARTS;
    bit m_dead = 0;
    bit m_inv = 0;
    int m_k = 0;
    bit m_dmg = 0;

    function automatic int sat_inc(input int h);
        return (h + 1 > MAX_HEARTS) ? MAX_HEARTS : h + 1;
    endfunction

    function automatic void model_step(input bit rn, input bit tk, input bit ht,
                                       input bit hl, input bit rs);
        m_dmg = 0;
        if (!rn || rs) begin
            m_hearts = MAX_HEARTS; m_dead = 0; m_inv = 0; m_k = 0;
        end else if (m_dead) begin
            m_hearts = 0;
        end else if (m_inv) begin
            if (hl) m_hearts = sat_inc(m_hearts);
            if (tk) begin
                m_k++;
                if (m_k >= INV_FRAMES) m_inv = 0;
            end
        end else if (ht) begin
            m_hearts--;
            m_dmg = 1;
            if (m_hearts == 0) m_dead = 1;
            else begin m_inv = 1; m_k = 0; end
        end else if (hl) begin
            m_hearts = sat_inc(m_hearts);
        end
    endfunction

    function automatic logic [5:0] model_exp();
        logic b;
        b = m_inv && (((m_k / BLINK_FRAMES) % 2) == 0);
        return {2'(m_hearts), m_inv, b, m_dmg, m_dead};
    endfunction

    task automatic drive(input bit rn, input bit tk, input bit ht, input bit hl, input bit rs);
        @(negedge clk);
        reset_n = rn; frame_tick = tk; hit = ht; heal = hl; restart = rs;
        @(posedge clk);
        model_step(rn, tk, ht, hl, rs);
        #1;
    endtask

    // Packed as {num_hearts, invincible, blink, damage_pulse, game_over}
    task automatic check(input string nm, input logic [5:0] exp);
        logic [5:0] act;
        act = {num_hearts, invincible, blink, damage_pulse, game_over};
        total++;
        if (act !== exp)
            $display("FAIL %s: got hearts/inv/blink/dmg/go=%b required %b at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    typedef struct {
        bit         rn, tk, ht, hl, rs;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rn, input bit tk, input bit ht, input bit hl,
                       input bit rs, input logic [5:0] exp);
        vec_t v;
        v.rn = rn; v.tk = tk; v.ht = ht; v.hl = hl; v.rs = rs; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic run_window(input bit ht);
        for (int i = 0; i < INV_FRAMES; i++) drive(1, 1, ht, 0, 0);
    endtask

    initial begin
        //  rn tk ht hl rs   hearts inv blink dmg go
        add(0, 0, 0, 0, 0, 6'b11_0000);   // reset
        add(1, 0, 0, 1, 0, 6'b11_0000);   // heal at ceiling
        add(1, 0, 1, 0, 0, 6'b10_1110);   // hit
        add(1, 0, 0, 0, 0, 6'b10_1100);   // pulse lasts one cycle
        add(1, 0, 1, 0, 0, 6'b10_1100);   // hit ignored in window
        add(1, 0, 0, 1, 0, 6'b11_1100);   // heal in window
        add(1, 0, 0, 1, 0, 6'b11_1100);   // saturates in window
        add(1, 1, 0, 0, 0, 6'b11_1100);   // one tick, blink holds
        add(1, 0, 1, 0, 1, 6'b11_0000);   // restart beats hit
        add(1, 0, 1, 0, 0, 6'b10_1110);
        add(1, 0, 0, 0, 1, 6'b11_0000);   // restart from window
        add(1, 0, 1, 1, 0, 6'b10_1110);   // hit wins over heal
        add(0, 0, 1, 0, 0, 6'b11_0000);   // reset beats hit
        add(1, 0, 1, 0, 0, 6'b10_1110);
        add(1, 1, 0, 1, 0, 6'b11_1100);   // tick and heal together
        add(1, 0, 0, 1, 1, 6'b11_0000);

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("reset_state", 6'b11_0000);

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].tk, vecs[i].ht, vecs[i].hl, vecs[i].rs);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Held hit across a full window, blink every 8 ticks
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        check("first_hit", 6'b10_1110);
        for (int i = 1; i <= INV_FRAMES; i++) begin
            logic b;
            drive(1, 1, 1, 0, 0);
            b = ((i / 8) % 2) == 0;
            if (i < INV_FRAMES) begin
                if (i % 8 == 0 || i % 8 == 7 || i == 1) check($sformatf("window_t%0d", i), {2'd2, 1'b1, b, 2'b00});
            end else begin
                check("window_end", 6'b10_0000);
            end
        end
        drive(1, 1, 1, 0, 0);
        check("held_hit_after_window", 6'b01_1110);

        // Three separated hits to game over
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        check("death_hit1", 6'b10_1110);
        run_window(0);
        drive(1, 0, 1, 1, 0);
        check("hit_heal_at2", 6'b01_1110);
        drive(1, 0, 0, 1, 0);
        check("heal_in_window_at1", 6'b10_1100);
        run_window(0);
        drive(1, 0, 1, 0, 0);
        check("death_hit2", 6'b01_1110);
        run_window(0);
        check("alive_at1", 6'b01_0000);
        drive(1, 0, 1, 0, 0);
        check("death_hit3", 6'b00_0011);
        drive(1, 1, 1, 1, 0);
        check("dead_ignores", 6'b00_0001);
        drive(1, 0, 0, 1, 0);
        check("dead_ignores_heal", 6'b00_0001);
        drive(1, 0, 0, 0, 1);
        check("restart_from_dead", 6'b11_0000);

        // Reset with 50 frames left in the window
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < INV_FRAMES - 50; i++) drive(1, 1, 0, 0, 0);
        check("mid_window", 6'b10_1100);
        drive(0, 0, 0, 0, 0);
        check("reset_mid_window", 6'b11_0000);

        // Randomized run against the model
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit rn, tk, ht, hl, rs;
            rn = ($urandom_range(0, 499) != 0);
            tk = ($urandom_range(0, 1) == 0);
            ht = ($urandom_range(0, 3) == 0);
            hl = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 299) == 0);
            drive(rn, tk, ht, hl, rs);
            check("random", model_exp());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
